// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: round-robin arbiter of one data-memory port between two requesters.
// Optional DM_ARB_ALIGN_CHECK_EN rejects size-misaligned requests at accept.
module dm_access_arbiter #(
   parameter int XLEN        = 64,
   parameter int MEM_LATENCY = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            p0_req_valid,
   output logic            p0_req_ready,
   input  logic            p0_req_write,
   input  logic [XLEN-1:0] p0_req_addr,
   input  logic [XLEN-1:0] p0_req_wdata,
   input  logic [2:0]      p0_req_type,
   output logic            p0_rsp_valid,
   output logic [XLEN-1:0] p0_rsp_data,
   output logic            p0_rsp_error,
   input  logic            p1_req_valid,
   output logic            p1_req_ready,
   input  logic            p1_req_write,
   input  logic [XLEN-1:0] p1_req_addr,
   input  logic [XLEN-1:0] p1_req_wdata,
   input  logic [2:0]      p1_req_type,
   output logic            p1_rsp_valid,
   output logic [XLEN-1:0] p1_rsp_data,
   output logic            p1_rsp_error,
   output logic            dm_read_enable,
   output logic            dm_write_enable,
   output logic [XLEN-1:0] dm_addr,
   output logic [XLEN-1:0] dm_write_data,
   input  logic [XLEN-1:0] dm_read_data,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
   state_t          r_state;
   logic            r_last, r_port, r_write, r_err;
   logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
   logic [2:0]      r_type;
   logic [3:0]      r_cnt;
   logic            w_any, w_port, w_write, w_bad, w_misalign, w_access, w_resp;
   logic [XLEN-1:0] w_addr, w_wdata, w_ext;
   logic [2:0]      w_type;
   assign w_any   = p0_req_valid | p1_req_valid;
   // on contention the port that did not win last time gets the grant
   assign w_port  = (p0_req_valid & p1_req_valid) ? ~r_last : p1_req_valid;
   assign w_write = w_port ? p1_req_write : p0_req_write;
   assign w_addr  = w_port ? p1_req_addr  : p0_req_addr;
   assign w_wdata = w_port ? p1_req_wdata : p0_req_wdata;
   assign w_type  = w_port ? p1_req_type  : p0_req_type;
`ifdef DM_ARB_ALIGN_CHECK_EN
   assign w_misalign = (w_type[1:0] == 2'd1 & w_addr[0]) |
                       (w_type[1:0] == 2'd2 & |w_addr[1:0]) |
                       (w_type[1:0] == 2'd3 & |w_addr[2:0]);
`else
   assign w_misalign = 1'b0;
`endif
   assign w_bad = (w_type == 3'd7) | w_misalign;
   always_comb begin
      w_ext = r_type == 3'd0 ? {{(XLEN-8){dm_read_data[7]}},   dm_read_data[7:0]}  :
              r_type == 3'd1 ? {{(XLEN-16){dm_read_data[15]}}, dm_read_data[15:0]} :
              r_type == 3'd2 ? {{(XLEN-32){dm_read_data[31]}}, dm_read_data[31:0]} :
              r_type == 3'd4 ? {{(XLEN-8){1'b0}},  dm_read_data[7:0]}  :
              r_type == 3'd5 ? {{(XLEN-16){1'b0}}, dm_read_data[15:0]} :
              r_type == 3'd6 ? {{(XLEN-32){1'b0}}, dm_read_data[31:0]} :
              dm_read_data;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_write <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_type  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_port  <= w_port;
               r_last  <= w_port;
               r_write <= w_write;
               r_addr  <= w_addr;
               r_wdata <= w_wdata;
               r_type  <= w_type;
               r_cnt   <= LAT_M1;
               r_err   <= w_bad;
               r_rdata <= '0;
               r_state <= w_bad ? RESP : ACCESS;
            end
            ACCESS: if (r_cnt == 4'd0) begin
               r_rdata <= r_write ? '0 : w_ext;
               r_state <= RESP;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: begin
               r_err   <= 1'b0;
               r_rdata <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign w_access        = r_state == ACCESS;
   assign w_resp          = r_state == RESP;
   assign busy            = r_state != IDLE;
   assign p0_req_ready    = ~reset & (r_state == IDLE) & w_any & ~w_port;
   assign p1_req_ready    = ~reset & (r_state == IDLE) & w_any & w_port;
   assign dm_read_enable  = w_access & ~r_write;
   assign dm_write_enable = w_access & r_write;
   assign dm_addr         = w_access ? r_addr : '0;
   assign dm_write_data   = w_access ? r_wdata : '0;
   assign p0_rsp_valid    = w_resp & ~r_port;
   assign p1_rsp_valid    = w_resp & r_port;
   assign p0_rsp_data     = p0_rsp_valid ? r_rdata : '0;
   assign p1_rsp_data     = p1_rsp_valid ? r_rdata : '0;
   assign p0_rsp_error    = p0_rsp_valid & r_err;
   assign p1_rsp_error    = p1_rsp_valid & r_err;
endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed self-checking bench for dm_access_arbiter (MEM_LATENCY=2).
module tb_dm_access_arbiter;
   localparam int XLEN = 64;
   logic            clk = 1'b0, reset = 1'b1;
   logic            p0_req_valid = 0, p0_req_ready, p0_req_write = 0;
   logic [XLEN-1:0] p0_req_addr = 0, p0_req_wdata = 0;
   logic [2:0]      p0_req_type = 0;
   logic            p0_rsp_valid, p0_rsp_error;
   logic [XLEN-1:0] p0_rsp_data;
   logic            p1_req_valid = 0, p1_req_ready, p1_req_write = 0;
   logic [XLEN-1:0] p1_req_addr = 0, p1_req_wdata = 0;
   logic [2:0]      p1_req_type = 0;
   logic            p1_rsp_valid, p1_rsp_error;
   logic [XLEN-1:0] p1_rsp_data;
   logic            dm_read_enable, dm_write_enable, busy;
   logic [XLEN-1:0] dm_addr, dm_write_data, dm_read_data = 0;
   int checks = 0, errors = 0;

   dm_access_arbiter #(.XLEN(XLEN), .MEM_LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_type(p0_req_type),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data), .p0_rsp_error(p0_rsp_error),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_type(p1_req_type),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data), .p1_rsp_error(p1_rsp_error),
      .dm_read_enable(dm_read_enable), .dm_write_enable(dm_write_enable),
      .dm_addr(dm_addr), .dm_write_data(dm_write_data), .dm_read_data(dm_read_data),
      .busy(busy));

   always #5 clk = ~clk;

   // Drives one request on a single port and observes the following six cycles.
   task automatic issue(input int port, input logic wr, input logic [2:0] ty,
                        input logic [XLEN-1:0] addr, input logic [XLEN-1:0] wd,
                        output logic rdy, output int n_rd, output int n_wr, output int rsp_cyc,
                        output logic [XLEN-1:0] rdata, output logic rerr, output logic bad);
      @(negedge clk);
      if (port == 0) begin
         p0_req_valid = 1; p0_req_write = wr; p0_req_type = ty; p0_req_addr = addr; p0_req_wdata = wd;
      end else begin
         p1_req_valid = 1; p1_req_write = wr; p1_req_type = ty; p1_req_addr = addr; p1_req_wdata = wd;
      end
      #1;
      rdy = (port == 0) ? (p0_req_ready && !p1_req_ready) : (p1_req_ready && !p0_req_ready);
      n_rd = 0; n_wr = 0; rsp_cyc = -1; rdata = 'x; rerr = 1'bx; bad = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         p0_req_valid = 0; p1_req_valid = 0;
         #1;
         if (dm_read_enable) n_rd++;
         if (dm_write_enable) n_wr++;
         if (dm_read_enable && dm_write_enable) bad = 1;
         if ((dm_read_enable || dm_write_enable) && dm_addr !== addr) bad = 1;
         if (dm_write_enable && dm_write_data !== wd) bad = 1;
         if (!dm_read_enable && !dm_write_enable && (dm_addr !== 0 || dm_write_data !== 0)) bad = 1;
         if ((port == 0 && p1_rsp_valid) || (port == 1 && p0_rsp_valid)) bad = 1;
         if (port == 0 && p0_rsp_valid && rsp_cyc < 0) begin rsp_cyc = c; rdata = p0_rsp_data; rerr = p0_rsp_error; end
         if (port == 1 && p1_rsp_valid && rsp_cyc < 0) begin rsp_cyc = c; rdata = p1_rsp_data; rerr = p1_rsp_error; end
      end
   endtask

   task automatic test_reset();
      reset = 1; p0_req_valid = 1;
      @(negedge clk); #1;
      checks++;
      if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, dm_read_enable, dm_write_enable, busy} !== 7'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 0000000", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, dm_read_enable, dm_write_enable, busy});
      end
      checks++;
      if (dm_addr !== 0 || dm_write_data !== 0 || p0_rsp_data !== 0 || p1_rsp_data !== 0) begin
         errors++; $display("FAIL reset_data got addr %h wdata %h exp 0", dm_addr, dm_write_data);
      end
      p0_req_valid = 0;
      @(negedge clk); reset = 0;
      @(negedge clk); #1;
      checks++;
      if (busy !== 0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_lb();
      logic rdy, rerr, bad; int n_rd, n_wr, rc; logic [XLEN-1:0] rd;
      dm_read_data = 64'h80;
      issue(0, 0, 3'd0, 64'h10, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rdy !== 1) begin errors++; $display("FAIL lb_ready got %b exp 1", rdy); end
      checks++; if (n_rd != 2 || n_wr != 0) begin errors++; $display("FAIL lb_enables got rd %0d wr %0d exp 2 0", n_rd, n_wr); end
      checks++; if (rc != 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", rc); end
      checks++; if (rd !== 64'hFFFFFFFFFFFFFF80 || rerr !== 0) begin errors++; $display("FAIL lb_data got %h err %b exp ffffffffffffff80 0", rd, rerr); end
      checks++; if (bad) begin errors++; $display("FAIL lb_bus got 1 exp 0"); end
   endtask

   task automatic test_lw_lwu();
      logic rdy, rerr, bad; int n_rd, n_wr, rc; logic [XLEN-1:0] rd;
      dm_read_data = 64'h00000000_80000001;
      issue(1, 0, 3'd6, 64'h18, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'h0000000080000001 || rc != 3 || rdy !== 1) begin errors++; $display("FAIL lwu_data got %h cyc %0d exp 0000000080000001 3", rd, rc); end
      issue(0, 0, 3'd2, 64'h18, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'hFFFFFFFF80000001 || rc != 3 || rdy !== 1) begin errors++; $display("FAIL lw_data got %h cyc %0d exp ffffffff80000001 3", rd, rc); end
      dm_read_data = 64'hFFFF_FFFF_FFFF_8001;
      issue(0, 0, 3'd5, 64'h20, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'h0000000000008001) begin errors++; $display("FAIL lhu_data got %h exp 0000000000008001", rd); end
      issue(0, 0, 3'd1, 64'h20, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'hFFFFFFFFFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffffffffffff8001", rd); end
      issue(0, 0, 3'd3, 64'h20, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'hFFFFFFFFFFFF8001) begin errors++; $display("FAIL ld_data got %h exp ffffffffffff8001", rd); end
      issue(0, 0, 3'd4, 64'h20, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rd !== 64'h0000000000000001) begin errors++; $display("FAIL lbu_data got %h exp 0000000000000001", rd); end
   endtask

   task automatic test_store();
      logic rdy, rerr, bad; int n_rd, n_wr, rc; logic [XLEN-1:0] rd;
      dm_read_data = 64'hDEAD;
      issue(1, 1, 3'd3, 64'h20, 64'h1234, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rdy !== 1) begin errors++; $display("FAIL st_ready got %b exp 1", rdy); end
      checks++; if (n_wr != 2 || n_rd != 0) begin errors++; $display("FAIL st_enables got wr %0d rd %0d exp 2 0", n_wr, n_rd); end
      checks++; if (rc != 3 || rd !== 0 || rerr !== 0) begin errors++; $display("FAIL st_rsp got cyc %0d data %h err %b exp 3 0 0", rc, rd, rerr); end
      checks++; if (bad) begin errors++; $display("FAIL st_bus got 1 exp 0"); end
   endtask

   task automatic test_reserved();
      logic rdy, rerr, bad; int n_rd, n_wr, rc; logic [XLEN-1:0] rd;
      dm_read_data = 64'h55;
      issue(0, 0, 3'd7, 64'h40, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
      checks++; if (rdy !== 1 || rc != 1) begin errors++; $display("FAIL rsv_latency got %0d exp 1", rc); end
      checks++; if (rerr !== 1 || rd !== 0) begin errors++; $display("FAIL rsv_rsp got err %b data %h exp 1 0", rerr, rd); end
      checks++; if (n_rd + n_wr != 0 || bad) begin errors++; $display("FAIL rsv_mem got %0d enables exp 0", n_rd + n_wr); end
   endtask

   task automatic test_align();
      logic rdy, rerr, bad; int n_rd, n_wr, rc; logic [XLEN-1:0] rd;
      dm_read_data = 64'h00000000_80000001;
      issue(1, 0, 3'd2, 64'h6, 0, rdy, n_rd, n_wr, rc, rd, rerr, bad);
`ifdef DM_ARB_ALIGN_CHECK_EN
      checks++; if (rdy !== 1 || rc != 1 || rerr !== 1 || rd !== 0) begin errors++; $display("FAIL align_rsp got cyc %0d err %b data %h exp 1 1 0", rc, rerr, rd); end
      checks++; if (n_rd + n_wr != 0 || bad) begin errors++; $display("FAIL align_mem got %0d enables exp 0", n_rd + n_wr); end
`else
      checks++; if (rdy !== 1 || rc != 3 || rerr !== 0 || rd !== 64'hFFFFFFFF80000001) begin errors++; $display("FAIL align_rsp got cyc %0d err %b data %h exp 3 0 ffffffff80000001", rc, rerr, rd); end
      checks++; if (n_rd != 2 || bad) begin errors++; $display("FAIL align_mem got %0d reads exp 2", n_rd); end
`endif
   endtask

   task automatic test_round_robin();
      int g[4]; int n = 0, nrsp = 0; logic bad = 0;
      reset = 1; @(negedge clk); reset = 0;
      dm_read_data = 64'h7;
      p0_req_write = 0; p1_req_write = 0; p0_req_type = 3'd3; p1_req_type = 3'd3;
      p0_req_addr = 64'h100; p1_req_addr = 64'h200;
      p0_req_valid = 1; p1_req_valid = 1;
      for (int c = 0; c < 40 && nrsp < 4; c++) begin
         #1;
         if (p0_req_rsp_conflict()) bad = 1;
         if (p0_rsp_valid && (n == 0 || g[n-1] != 0 || p0_rsp_data !== 64'h7)) bad = 1;
         if (p1_rsp_valid && (n == 0 || g[n-1] != 1 || p1_rsp_data !== 64'h7)) bad = 1;
         if (p0_rsp_valid || p1_rsp_valid) nrsp++;
         if (p0_req_ready && n < 4) begin g[n] = 0; n++; end
         else if (p1_req_ready && n < 4) begin g[n] = 1; n++; end
         @(negedge clk);
         if (n == 4) begin p0_req_valid = 0; p1_req_valid = 0; end
      end
      checks++; if (n != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", n); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (i < n && g[i] != i % 2) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", i, g[i], i % 2); end
      end
      checks++; if (nrsp != 4 || bad) begin errors++; $display("FAIL rr_rsp got %0d routed ok %b exp 4 1", nrsp, !bad); end
      repeat (4) @(negedge clk);
   endtask

   function automatic logic p0_req_rsp_conflict();
      return p0_rsp_valid && p1_rsp_valid;
   endfunction

   task automatic test_reset_mid();
      int stray = 0;
      @(negedge clk);
      p0_req_valid = 1; p0_req_write = 0; p0_req_type = 3'd3; p0_req_addr = 64'h30;
      #1;
      checks++; if (p0_req_ready !== 1) begin errors++; $display("FAIL rm_accept got %b exp 1", p0_req_ready); end
      @(negedge clk); p0_req_valid = 0; #1;
      checks++; if (dm_read_enable !== 1) begin errors++; $display("FAIL rm_access got %b exp 1", dm_read_enable); end
      reset = 1; #1;
      checks++; if (dm_read_enable !== 0 || busy !== 0) begin errors++; $display("FAIL rm_abort got re %b busy %b exp 0 0", dm_read_enable, busy); end
      @(negedge clk); reset = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (p0_rsp_valid || p1_rsp_valid || busy) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rm_no_rsp got %0d stray cycles exp 0", stray); end
      @(negedge clk); p0_req_valid = 1; p1_req_valid = 1; #1;
      checks++; if (p0_req_ready !== 1 || p1_req_ready !== 0) begin errors++; $display("FAIL rm_next_grant got p0 %b p1 %b exp 1 0", p0_req_ready, p1_req_ready); end
      @(negedge clk); p0_req_valid = 0; p1_req_valid = 0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lb();
      test_lw_lwu();
      test_store();
      test_reserved();
      test_align();
      test_round_robin();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Arbitrates one data-memory port between two requesters: port 0 is the pipeline memory-access stage and port 1 is a debug/DMA master. The block accepts one request at a time with a valid/ready handshake and holds the memory enables for a fixed MEM_LATENCY cycles. It then returns the load result, sign- or zero-extended per the access type, with a one-cycle response pulse. It sits between the memory-access stage and dataMemory.

Parameters:
XLEN, 64, data and address width
MEM_LATENCY, 2, cycles the memory enables are held per access; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
p0_req_valid  input  1  port 0 request present
p0_req_ready  output  1  port 0 request accepted this cycle
p0_req_write  input  1  1 = store, 0 = load
p0_req_addr  input  XLEN  byte address
p0_req_wdata  input  XLEN  store data, LSB-aligned
p0_req_type  input  3  0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 reserved; stores use size only (0/4 B, 1/5 H, 2/6 W, 3 D)
p0_rsp_valid  output  1  one-cycle response pulse
p0_rsp_data  output  XLEN  extended load data; 0 for stores
p0_rsp_error  output  1  access rejected, qualified by rsp_valid
p1_*  (same nine signals and meanings as p0_*)  port 1
dm_read_enable  output  1  memory read strobe
dm_write_enable  output  1  memory write strobe
dm_addr  output  XLEN  memory address, drives both read and write address
dm_write_data  output  XLEN  memory write data
dm_read_data  input  XLEN  memory read data, valid while dm_read_enable is high
busy  output  1  high in every state other than IDLE

Behaviour:
- Reset (asynchronous, active-high) forces all outputs to 0, the FSM to IDLE, and last_grant to 1.
- FSM states are IDLE, ACCESS and RESP.
- IDLE, arbitration:
  - If exactly one port is valid, grant that port.
  - If both are valid, grant the port that is not last_grant (round robin). After reset, port 0 wins first.
  - The granted port's req_ready is asserted combinationally in the same cycle. req_ready is 0 in every other state.
  - On grant, register write, addr, wdata, type and the port id; update last_grant; go to ACCESS and load the counter with MEM_LATENCY-1.
- ACCESS:
  - dm_read_enable equals !write and dm_write_enable equals write. Never assert both in the same cycle.
  - dm_addr and dm_write_data come from the registered request and stay stable for the whole state.
  - The counter decrements each cycle. When it reaches 0, capture the extended dm_read_data and go to RESP.
- Load extension:
  - Types 0, 1, 2: sign-extend bits [7:0], [15:0] and [31:0] respectively.
  - Type 3: pass the full XLEN.
  - Types 4, 5, 6: zero-extend bits [7:0], [15:0] and [31:0] respectively.
- Reserved type (7): skip ACCESS entirely (memory untouched) and go straight to RESP with rsp_error=1 and rsp_data=0.
- RESP: assert rsp_valid for one cycle on the granted port only; go to IDLE. The block does not arbitrate in RESP; the next grant happens in IDLE, one cycle later.
- Latency: if a request is accepted in cycle T, the enables are high for T+1 .. T+MEM_LATENCY and rsp_valid rises in T+MEM_LATENCY+1.
- Request inputs are ignored while busy. A requester must hold valid and its fields stable until it sees ready.
- When neither enable is high, dm_addr and dm_write_data are driven to 0.
- Reset mid-access aborts the access immediately: enables drop asynchronously and no response is generated.

Optional Feature:
DM_ARB_ALIGN_CHECK_EN
- Defined: in IDLE, a granted request whose address is not size-aligned is flagged at accept. H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0. The block skips ACCESS, issues RESP with rsp_error=1 and rsp_data=0, and the memory is never enabled.
- Undefined: no alignment check; unaligned addresses pass to memory unchanged and rsp_error is asserted only for type 7.

Test Plan:
- Single LB: p0 load type 0 at addr 0x10, memory returns 0x...80 -> p0_rsp_data=0xFFFFFFFFFFFFFF80 at T+3 (MEM_LATENCY=2); dm_read_enable high exactly 2 cycles.
- LWU versus LW on data 0x00000000_8000_0001 -> rsp_data 0x0000000080000001 (LWU) and 0xFFFFFFFF80000001 (LW).
- Both ports valid every cycle for 4 grants -> grant order p0, p1, p0, p1; each response reaches only its own port.
- p1 store, addr 0x20, wdata 0x1234 -> dm_write_enable high 2 cycles with dm_addr=0x20 and dm_write_data=0x1234; dm_read_enable stays 0; p1_rsp_valid=1 with rsp_data=0.
- Type 7 request, and with DM_ARB_ALIGN_CHECK_EN defined an LW at 0x6 -> both give rsp_error=1 one cycle after accept, and no memory enable is ever asserted.
- Assert reset during the ACCESS cycle of a load -> enables drop the same cycle, no rsp_valid is seen, and the next request after reset is granted to p0.
